// File: rtl/pru_raster_pkg.sv
// Shared types for the raster engine: command opcodes and controller states.
package pru_raster_pkg;

  typedef enum logic [2:0] {
    OP_CLEAR        = 3'd0,
    OP_RECT_FILL    = 3'd1,
    OP_RECT_OUTLINE = 3'd2,
    OP_CIRCLE_FILL  = 3'd3,
    OP_BITMAP       = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SCAN   = 3'd2,
    DRAIN  = 3'd3,
    FINISH = 3'd4
  } state_e;

  function automatic logic op_reserved(input logic [2:0] op);
    return op > 3'd4;
  endfunction

endpackage

// File: rtl/pru_bbox_clip.sv
// Combinational bounding box for one draw command: unclipped extents for edge tests,
// clamped scan window, and an empty flag when nothing can be written.
module pru_bbox_clip
  import pru_raster_pkg::*;
#(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int XW    = $clog2(H_RES),
  parameter int YW    = $clog2(V_RES)
) (
  input  logic [2:0]           op,
  input  logic [XW-1:0]        x,
  input  logic [YW-1:0]        y,
  input  logic [XW-1:0]        w,
  input  logic [YW-1:0]        h,
  output logic signed [XW+1:0] ux0,
  output logic signed [XW+1:0] ux1,
  output logic signed [YW+1:0] uy0,
  output logic signed [YW+1:0] uy1,
  output logic [XW-1:0]        bx0,
  output logic [XW-1:0]        bx1,
  output logic [YW-1:0]        by0,
  output logic [YW-1:0]        by1,
  output logic                 empty,
  output logic                 reserved
);

  localparam logic signed [XW+1:0] X_MAX  = (XW+2)'(H_RES - 1);
  localparam logic signed [YW+1:0] Y_MAX  = (YW+2)'(V_RES - 1);
  localparam logic signed [XW+1:0] X_ONE  = (XW+2)'(1);
  localparam logic signed [YW+1:0] Y_ONE  = (YW+2)'(1);
  localparam logic [XW-1:0]        X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0]        Y_LAST = YW'(V_RES - 1);

  logic signed [XW+1:0] sx, sw, sr;
  logic signed [YW+1:0] sy, sh;
  logic                 zero_size;

  assign sx = $signed({2'b00, x});
  assign sw = $signed({2'b00, w});
  assign sr = $signed((XW+2)'(h));
  assign sy = $signed({2'b00, y});
  assign sh = $signed({2'b00, h});

  always_comb begin
    reserved  = op_reserved(op);
    ux0       = '0;
    ux1       = X_MAX;
    uy0       = '0;
    uy1       = Y_MAX;
    zero_size = 1'b0;
    case (op)
      OP_RECT_FILL, OP_RECT_OUTLINE, OP_BITMAP: begin
        ux0       = sx;
        ux1       = sx + sw - X_ONE;
        uy0       = sy;
        uy1       = sy + sh - Y_ONE;
        zero_size = (w == '0) || (h == '0);
      end
      // Radius travels in h, so a zero radius is treated like a zero-size command.
      OP_CIRCLE_FILL: begin
        ux0       = sx - sr;
        ux1       = sx + sr;
        uy0       = sy - sh;
        uy1       = sy + sh;
        zero_size = (h == '0);
      end
      default: ;
    endcase

    bx0 = ux0[XW+1] ? '0 : ux0[XW-1:0];
    bx1 = (ux1 > X_MAX) ? X_LAST : ux1[XW-1:0];
    by0 = uy0[YW+1] ? '0 : uy0[YW-1:0];
    by1 = (uy1 > Y_MAX) ? Y_LAST : uy1[YW-1:0];

    empty = reserved || zero_size || (ux0 > X_MAX) || (uy0 > Y_MAX) ||
            ux1[XW+1] || uy1[YW+1];
  end

endmodule

// File: rtl/pru_raster_engine.sv
// Pixel rasteriser: scans the clipped bounding box of one command row-major and
// streams kept pixels as framebuffer writes through a two-stage pipeline.
module pru_raster_engine
  import pru_raster_pkg::*;
#(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int COLOR_W = 2,
  parameter int BMP_AW  = 10,
  parameter int XW      = $clog2(H_RES),
  parameter int YW      = $clog2(V_RES),
  parameter int FB_AW   = $clog2(H_RES*V_RES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic [XW-1:0]      cmd_x,
  input  logic [YW-1:0]      cmd_y,
  input  logic [XW-1:0]      cmd_w,
  input  logic [YW-1:0]      cmd_h,
  input  logic [BMP_AW-1:0]  cmd_bmp_base,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [FB_AW-1:0]   pix_addr,
  output logic [COLOR_W-1:0] pix_data,
  output logic               bmp_rd_en,
  output logic [BMP_AW-1:0]  bmp_rd_addr,
  input  logic               bmp_rd_data,
  output logic               busy,
  output logic               done,
  output logic               err,
  output state_e             dbg_state
);

  // Handshakes: a transfer happens on a cycle where valid && ready are both high;
  // a producer holding valid keeps its payload unchanged until that cycle.

  localparam logic [FB_AW-1:0] H_STEP = FB_AW'(H_RES);

  state_e state_q, state_d;

  logic [2:0]         op_q;
  logic [COLOR_W-1:0] color_q;
  logic [XW-1:0]      x_q, w_q;
  logic [YW-1:0]      y_q, h_q;
  logic [BMP_AW-1:0]  base_q;

  logic signed [XW+1:0] c_ux0, c_ux1;
  logic signed [YW+1:0] c_uy0, c_uy1;
  logic [XW-1:0]        c_bx0, c_bx1;
  logic [YW-1:0]        c_by0, c_by1;
  logic                 c_empty, c_reserved;

  logic [XW-1:0]     cx_q;
  logic [YW-1:0]     cy_q;
  logic [FB_AW-1:0]  fb_addr_q, row_base_q, row_start;
  logic [BMP_AW-1:0] bmp_addr_q, bmp_row_q, bmp_step;

  logic               s1_valid_q, s1_keep_q, s1_bmp_q;
  logic [FB_AW-1:0]   pix_addr_q;
  logic [COLOR_W-1:0] pix_data_q;

  logic scanning, stall, adv, last_col, last_row, keep0, on_edge;

  logic signed [XW+1:0] dx_s;
  logic signed [YW+1:0] dy_s;
  logic [XW:0]          adx, ady;
  logic [2*XW+1:0]      adx_w, ady_w, rad_w, dist2, r2;

  pru_bbox_clip #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .XW    (XW),
    .YW    (YW)
  ) u_bbox (
    .op       (op_q),
    .x        (x_q),
    .y        (y_q),
    .w        (w_q),
    .h        (h_q),
    .ux0      (c_ux0),
    .ux1      (c_ux1),
    .uy0      (c_uy0),
    .uy1      (c_uy1),
    .bx0      (c_bx0),
    .bx1      (c_bx1),
    .by0      (c_by0),
    .by1      (c_by1),
    .empty    (c_empty),
    .reserved (c_reserved)
  );

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = !cmd_ready;
  assign done        = (state_q == FINISH);
  assign err         = done && c_reserved;
  assign dbg_state   = state_q;
  assign pix_valid   = s1_valid_q && (s1_bmp_q ? bmp_rd_data : s1_keep_q);
  assign pix_addr    = pix_addr_q;
  assign pix_data    = pix_data_q;
  assign bmp_rd_addr = bmp_addr_q;

  assign scanning  = (state_q == SCAN);
  assign stall     = pix_valid && !pix_ready;
  assign adv       = scanning && !stall;
  assign last_col  = (cx_q == c_bx1);
  assign last_row  = (cy_q == c_by1);
  assign bmp_rd_en = adv && (op_q == OP_BITMAP);
  assign bmp_step  = BMP_AW'(w_q);
  // Constant-coefficient product, evaluated once per command in SETUP only.
  assign row_start = FB_AW'(c_by0) * H_STEP;

  assign dx_s  = $signed({2'b00, cx_q}) - $signed({2'b00, x_q});
  assign dy_s  = $signed({2'b00, cy_q}) - $signed({2'b00, y_q});
  assign adx   = dx_s[XW+1] ? (XW+1)'(-dx_s) : (XW+1)'(dx_s);
  assign ady   = dy_s[YW+1] ? (XW+1)'(-dy_s) : (XW+1)'(dy_s);
  assign adx_w = (2*XW+2)'(adx);
  assign ady_w = (2*XW+2)'(ady);
  assign rad_w = (2*XW+2)'(h_q);
  assign dist2 = adx_w * adx_w + ady_w * ady_w;
  assign r2    = rad_w * rad_w;

  assign on_edge = ($signed({2'b00, cx_q}) == c_ux0) || ($signed({2'b00, cx_q}) == c_ux1) ||
                   ($signed({2'b00, cy_q}) == c_uy0) || ($signed({2'b00, cy_q}) == c_uy1);

  // Bitmap pixels are kept or dropped later, once the ROM bit arrives in stage 1.
  always_comb begin
    keep0 = 1'b0;
    case (op_q)
      OP_CLEAR, OP_RECT_FILL, OP_BITMAP: keep0 = 1'b1;
      OP_RECT_OUTLINE:                   keep0 = on_edge;
      OP_CIRCLE_FILL:                    keep0 = (dist2 <= r2);
      default:                           keep0 = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = SETUP;
      SETUP:   state_d = c_empty ? FINISH : SCAN;
      SCAN:    if (adv && last_col && last_row) state_d = DRAIN;
      DRAIN:   if (!stall) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      color_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      base_q  <= '0;
    end else if (cmd_valid && cmd_ready) begin
      op_q    <= cmd_op;
      color_q <= cmd_color;
      x_q     <= cmd_x;
      y_q     <= cmd_y;
      w_q     <= cmd_w;
      h_q     <= cmd_h;
      base_q  <= cmd_bmp_base;
    end
  end

  // Stage 0 counters. A bitmap box never clips on the left or top, so each
  // bitmap row starts exactly one bitmap width after the previous one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx_q       <= '0;
      cy_q       <= '0;
      fb_addr_q  <= '0;
      row_base_q <= '0;
      bmp_addr_q <= '0;
      bmp_row_q  <= '0;
    end else if (state_q == SETUP) begin
      cx_q       <= c_bx0;
      cy_q       <= c_by0;
      row_base_q <= row_start;
      fb_addr_q  <= row_start + FB_AW'(c_bx0);
      bmp_row_q  <= base_q;
      bmp_addr_q <= base_q;
    end else if (adv) begin
      if (last_col) begin
        cx_q       <= c_bx0;
        cy_q       <= cy_q + YW'(1);
        row_base_q <= row_base_q + H_STEP;
        fb_addr_q  <= row_base_q + H_STEP + FB_AW'(c_bx0);
        bmp_row_q  <= bmp_row_q + bmp_step;
        bmp_addr_q <= bmp_row_q + bmp_step;
      end else begin
        cx_q       <= cx_q + XW'(1);
        fb_addr_q  <= fb_addr_q + FB_AW'(1);
        bmp_addr_q <= bmp_addr_q + BMP_AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_keep_q  <= 1'b0;
      s1_bmp_q   <= 1'b0;
      pix_addr_q <= '0;
      pix_data_q <= '0;
    end else if (!stall) begin
      s1_valid_q <= scanning;
      if (scanning) begin
        s1_keep_q  <= keep0;
        s1_bmp_q   <= (op_q == OP_BITMAP);
        pix_addr_q <= fb_addr_q;
        pix_data_q <= color_q;
      end
    end
  end

endmodule

// File: tb/tb_pru_raster_engine.sv
// Directed bench for pru_raster_engine: write scoreboard, ROM model and stall checks.
module tb_pru_raster_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_color;
  logic [9:0]  cmd_x;
  logic [8:0]  cmd_y;
  logic [9:0]  cmd_w;
  logic [8:0]  cmd_h;
  logic [9:0]  cmd_bmp_base;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [18:0] pix_addr;
  logic [1:0]  pix_data;
  logic        bmp_rd_en;
  logic [9:0]  bmp_rd_addr;
  logic        bmp_rd_data = 1'b0;
  logic        busy;
  logic        done;
  logic        err;
  pru_raster_pkg::state_e dbg_state;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int ready_mode = 1;

  logic [18:0] exp_q[$];
  logic [9:0]  bmp_exp_q[$];
  logic [1:0]  exp_color;
  logic        rom [0:1023];

  logic        hold_chk = 1'b0;
  logic [18:0] hold_addr;
  logic [1:0]  hold_data;

  pru_raster_engine dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_color    (cmd_color),
    .cmd_x        (cmd_x),
    .cmd_y        (cmd_y),
    .cmd_w        (cmd_w),
    .cmd_h        (cmd_h),
    .cmd_bmp_base (cmd_bmp_base),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_addr     (pix_addr),
    .pix_data     (pix_data),
    .bmp_rd_en    (bmp_rd_en),
    .bmp_rd_addr  (bmp_rd_addr),
    .bmp_rd_data  (bmp_rd_data),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .dbg_state    (dbg_state)
  );

  // clock / ROM model / ready driver
  always #5 clk = ~clk;

  always @(posedge clk) if (bmp_rd_en) bmp_rd_data <= rom[bmp_rd_addr];

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       pix_ready = 1'b0;
      1:       pix_ready = 1'b1;
      default: pix_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // scoreboard: every accepted write must match the head of exp_q
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        checks++;
        assert (pix_valid === 1'b1 && pix_addr === hold_addr && pix_data === hold_data)
        else begin
          errors++;
          $error("FAIL stall_hold valid=%0b addr=%0d data=%0d required valid=1 addr=%0d data=%0d",
                 pix_valid, pix_addr, pix_data, hold_addr, hold_data);
        end
      end
      hold_chk  = pix_valid && !pix_ready;
      hold_addr = pix_addr;
      hold_data = pix_data;
      if (pix_valid === 1'b1 && pix_ready) begin
        logic [18:0] e;
        wr_count++;
        e = '1;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        checks++;
        assert ({pix_addr, pix_data} === {e, exp_color})
        else begin
          errors++;
          $error("FAIL write addr=%0d data=%0d required addr=%0d data=%0d", pix_addr, pix_data, e, exp_color);
        end
      end
      if (bmp_rd_en === 1'b1) begin
        logic [9:0] b;
        b = '1;
        if (bmp_exp_q.size() != 0) b = bmp_exp_q.pop_front();
        checks++;
        assert (bmp_rd_addr === b)
        else begin
          errors++;
          $error("FAIL bmp_read addr=%0d required %0d", bmp_rd_addr, b);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input int x, input int y, input int w, input int h,
                      input logic [1:0] col, input int base);
    @(posedge clk); #1;
    cmd_valid    = 1'b1;
    cmd_op       = op;
    cmd_x        = 10'(x);
    cmd_y        = 9'(y);
    cmd_w        = 10'(w);
    cmd_h        = 9'(h);
    cmd_color    = col;
    cmd_bmp_base = 10'(base);
    exp_color    = col;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input logic exp_err, input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done !== 1'b1 && cyc < max_cyc);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int wr_snap;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0; cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0;
    cmd_color = '0; cmd_bmp_base = '0; exp_color = '0;
    for (int i = 0; i < 1024; i++) rom[i] = 1'b0;
    rom[100] = 1'b1;
    rom[103] = 1'b1;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_bmp_rd_en", 32'(bmp_rd_en), 0);
    chk("rst_pix_addr", 32'(pix_addr), 0);
    chk("rst_pix_data", 32'(pix_data), 0);
    chk("rst_bmp_rd_addr", 32'(bmp_rd_addr), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // right-edge clipping
    exp_q.push_back(19'd7038); exp_q.push_back(19'd7039);
    exp_q.push_back(19'd7678); exp_q.push_back(19'd7679);
    send(3'd1, 638, 10, 4, 2, 2'd3, 0);
    wait_done(100, 1'b0, "rect_clip", cyc);
    chk("rect_clip_left", 32'(exp_q.size()), 0);
    @(negedge clk);
    chk("rect_clip_ready", 32'(cmd_ready), 1);

    // filled circle r=1
    exp_q.push_back(19'd2565); exp_q.push_back(19'd3204); exp_q.push_back(19'd3205);
    exp_q.push_back(19'd3206); exp_q.push_back(19'd3845);
    send(3'd3, 5, 5, 0, 1, 2'd1, 0);
    wait_done(100, 1'b0, "circle", cyc);
    chk("circle_left", 32'(exp_q.size()), 0);

    // outline with random backpressure
    ready_mode = 2;
    exp_q.push_back(19'd0);    exp_q.push_back(19'd1);    exp_q.push_back(19'd2);
    exp_q.push_back(19'd640);  exp_q.push_back(19'd642);
    exp_q.push_back(19'd1280); exp_q.push_back(19'd1281); exp_q.push_back(19'd1282);
    send(3'd2, 0, 0, 3, 3, 2'd2, 0);
    wait_done(300, 1'b0, "outline", cyc);
    chk("outline_left", 32'(exp_q.size()), 0);
    ready_mode = 1;

    // bitmap 2x2, bits 1,0,0,1
    bmp_exp_q.push_back(10'd100); bmp_exp_q.push_back(10'd101);
    bmp_exp_q.push_back(10'd102); bmp_exp_q.push_back(10'd103);
    exp_q.push_back(19'd0); exp_q.push_back(19'd641);
    send(3'd4, 0, 0, 2, 2, 2'd3, 100);
    wait_done(100, 1'b0, "bitmap", cyc);
    chk("bitmap_left", 32'(exp_q.size()), 0);
    chk("bitmap_reads_left", 32'(bmp_exp_q.size()), 0);

    // zero width: quick finish, no writes
    wr_snap = wr_count;
    send(3'd1, 10, 10, 0, 5, 2'd1, 0);
    wait_done(3, 1'b0, "w0", cyc);
    chk("w0_latency_ok", 32'(cyc <= 3), 1);
    chk("w0_writes", 32'(wr_count - wr_snap), 0);

    // reserved op
    @(negedge clk);
    wr_snap = wr_count;
    send(3'd6, 0, 0, 4, 4, 2'd1, 0);
    wait_done(10, 1'b1, "op6", cyc);
    chk("op6_writes", 32'(wr_count - wr_snap), 0);

    // command offered while busy is dropped
    @(negedge clk);
    exp_q.push_back(19'd660); exp_q.push_back(19'd661);
    exp_q.push_back(19'd662); exp_q.push_back(19'd663);
    send(3'd1, 20, 1, 4, 1, 2'd2, 0);
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_x = 10'd100; cmd_y = 9'd100; cmd_h = 9'd2; cmd_color = 2'd1;
    @(negedge clk);
    chk("busy_ready0_a", 32'(cmd_ready), 0);
    chk("busy_flag", 32'(busy), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_ready0_b", 32'(cmd_ready), 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_done(100, 1'b0, "busy_cmd", cyc);
    chk("busy_cmd_left", 32'(exp_q.size()), 0);
    repeat (3) @(negedge clk);
    chk("busy_second_dropped", 32'(busy), 0);

    // reset mid-CLEAR while stalled
    ready_mode = 0;
    send(3'd0, 0, 0, 0, 0, 2'd1, 0);
    repeat (4) @(negedge clk);
    chk("clear_stalled_valid", 32'(pix_valid), 1);
    chk("clear_stalled_addr", 32'(pix_addr), 0);
    wr_snap = wr_count;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_pix_valid", 32'(pix_valid), 0);
    chk("arst_cmd_ready", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_mode = 1;
    repeat (20) @(negedge clk);
    chk("arst_no_writes", 32'(wr_count - wr_snap), 0);
    chk("arst_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pru_raster_engine.md
Name: pru_raster_engine

Overview:
Parametrised pixel rasteriser and successor to the current fixed 640x480 / 2-bit drawing unit. It accepts one draw command at a time: clear, filled rect, outlined rect, filled circle, or 1-bpp bitmap. It emits clipped framebuffer write transactions (address + colour) on a valid/ready stream. The framebuffer RAM and the bitmap ROM are external, so one engine can serve any resolution or colour depth.

Parameters:
H_RES, 640, visible columns
V_RES, 480, visible rows
COLOR_W, 2, colour index width
BMP_AW, 10, bitmap ROM address width
XW, $clog2(H_RES), x coordinate width (derived)
YW, $clog2(V_RES), y coordinate width (derived)
FB_AW, $clog2(H_RES*V_RES), framebuffer address width (derived)

Ports:
clk  in  1  system clock
rst_n  in  1  reset
cmd_valid  in  1  command offered
cmd_ready  out  1  engine accepts command (high only in IDLE)
cmd_op  in  3  0 CLEAR, 1 RECT_FILL, 2 RECT_OUTLINE, 3 CIRCLE_FILL, 4 BITMAP, 5-7 reserved
cmd_color  in  COLOR_W  colour written
cmd_x  in  XW  rect/bitmap left column; circle centre column
cmd_y  in  YW  rect/bitmap top row; circle centre row
cmd_w  in  XW  rect/bitmap width
cmd_h  in  YW  rect/bitmap height; circle radius
cmd_bmp_base  in  BMP_AW  bitmap ROM start address
pix_valid  out  1  write transaction valid
pix_ready  in  1  framebuffer accepts write
pix_addr  out  FB_AW  y*H_RES + x
pix_data  out  COLOR_W  colour
bmp_rd_en  out  1  bitmap ROM read strobe
bmp_rd_addr  out  BMP_AW  bitmap ROM address
bmp_rd_data  in  1  bitmap bit, valid 1 cycle after bmp_rd_en; ROM holds it while bmp_rd_en low
busy  out  1  command in progress
done  out  1  one-cycle pulse at command completion
err  out  1  one-cycle pulse with done for a reserved op

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: cmd_ready=1, busy=0, done=0, err=0, pix_valid=0, bmp_rd_en=0, pix_addr=0, pix_data=0, bmp_rd_addr=0. Reset mid-command abandons the command; no further writes are issued.
- Handshakes: a command is accepted on cmd_valid && cmd_ready. All cmd_* fields are latched then. A pixel transfer completes on pix_valid && pix_ready. pix_addr/pix_data stay stable while pix_valid && !pix_ready.
- FSM states: IDLE, SETUP, SCAN, DRAIN, FINISH.
  - IDLE -> SETUP on accept.
  - SETUP (1 cycle) computes the bounding box. Reserved op, w==0 or h==0 -> FINISH with no writes (err=1 for reserved op).
  - SETUP -> SCAN.
  - SCAN -> DRAIN after the last candidate enters the output stage.
  - DRAIN -> FINISH once the output stage is empty.
  - FINISH pulses done for 1 cycle -> IDLE.
- Bounding box per op:
  - CLEAR: 0..H_RES-1 x 0..V_RES-1.
  - RECT and BITMAP: [x, x+w-1] x [y, y+h-1].
  - CIRCLE: [x-r, x+r] x [y-r, y+r].
  - Bounds are computed at XW+2 / YW+2 bits signed, with no wrap. Negative start clamps to 0. End clamps to H_RES-1 / V_RES-1. A fully off-screen box writes nothing.
- Scan order: row-major, x inner, one candidate per cycle when not stalled. Address is formed incrementally (row base += H_RES per row, +1 per column); no multiplier.
- Pipeline: stage0 generates coordinates and issues bmp_rd_en; stage1 registers the candidate. stage1 becomes pix_valid only if the pixel is kept:
  - RECT_OUTLINE: keep when on the first/last row or first/last column of the unclipped rect.
  - CIRCLE_FILL: keep when dx^2 + dy^2 <= r^2, computed in 2*(XW+1)-bit unsigned.
  - BITMAP: keep when bmp_rd_data == 1. A 0 bit is transparent.
- Bitmap addressing: bmp_rd_addr = base + (row_in_bmp*w + col_in_bmp), kept as an incrementing counter. Clipped bitmap pixels still advance the counter. bmp_rd_addr wraps mod 2^BMP_AW.
- Stall: while pix_valid && !pix_ready, stage0 holds and bmp_rd_en=0.
- Latency: first pix_valid appears no earlier than 3 cycles after accept. Throughput is 1 write/cycle with pix_ready held high.
- busy = !cmd_ready. cmd_valid while busy is ignored (not queued).

Decomposition:
- Package pru_raster_pkg: op enum (op_e), state enum (state_e), op encodings.
- Sub-module pru_bbox_clip: combinational bounding-box compute and clamp, instantiated in SETUP.
- Keep/discard logic and the address/bitmap counters stay in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-CLEAR with pix_ready=0 -> pix_valid=0, cmd_ready=1 immediately; no further writes after release.
- Right-edge clipping (H_RES=640): RECT_FILL x=638 y=10 w=4 h=2, pix_ready=1 -> exactly addrs 7038, 7039, 7678, 7679 in order, then done pulse; cmd_ready returns next cycle.
- CIRCLE_FILL x=5 y=5 r=1 -> addrs 2565, 3204, 3205, 3206, 3845 only.
- RECT_OUTLINE x=0 y=0 w=3 h=3 with pix_ready random 50% -> 8 addrs {0,1,2,640,642,1280,1281,1282}, no duplicates or losses; addr/data stable while stalled.
- BITMAP x=0 y=0 w=2 h=2 base=100, ROM bits 100..103 = 1,0,0,1 -> bmp_rd_addr 100..103 issued; writes only addrs 0 and 641.
- Edge commands:
  - w=0 -> done within 3 cycles, zero pix_valid.
  - op=6 -> done and err pulse together.
  - second cmd_valid during busy -> not accepted.
